decode_pipe: RTL and testbench

DECODE_PIPE -- requirements
Module: decode_pipe

---
 rtl/decode_pipe.sv | 198 +++++++++++++++++++
 tb/tb_decode_pipe.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_pipe.sv
// decode_pipe: MIPS-style ID stage with load-use interlock and ID/EX register.
// Ports: IF/ID inputs, regfile read data, stall/flush in; hazard/jump out, ID/EX fields, bubble_cnt.
module decode_pipe #(
  parameter int XLEN  = 32,
  parameter int RA_W  = 5,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             if_valid,
  input  logic [XLEN-1:0]  if_pc4,
  input  logic [31:0]      if_instr,
  input  logic [XLEN-1:0]  rs_data,
  input  logic [XLEN-1:0]  rt_data,
  input  logic             stall_in,
  input  logic             flush_in,
  output logic             hazard_stall,
  output logic             jump_redirect,
  output logic [XLEN-1:0]  jump_target,
  output logic             ex_valid,
  output logic [XLEN-1:0]  ex_pc4,
  output logic [XLEN-1:0]  ex_rs_data,
  output logic [XLEN-1:0]  ex_rt_data,
  output logic [XLEN-1:0]  ex_imm,
  output logic [XLEN-1:0]  ex_br_target,
  output logic [RA_W-1:0]  ex_rs,
  output logic [RA_W-1:0]  ex_rt,
  output logic [RA_W-1:0]  ex_dst,
  output logic [3:0]       ex_alu_ctrl,
  output logic             ex_regwrite,
  output logic             ex_memread,
  output logic             ex_memwrite,
  output logic             ex_memtoreg,
  output logic             ex_alusrc,
  output logic             ex_branch,
  output logic             ex_illegal,
  output logic [CNT_W-1:0] bubble_cnt
);

  typedef struct packed {
    logic regwrite;
    logic memread;
    logic memwrite;
    logic memtoreg;
    logic alusrc;
    logic branch;
    logic illegal;
  } ctrl_t;

  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_SLT = 4'b0111;

  logic [5:0] op;
  logic [5:0] funct;
  logic [RA_W-1:0] rs;
  logic [RA_W-1:0] rt;
  logic [RA_W-1:0] rd;
  logic unused_shamt;

  assign op    = if_instr[31:26];
  assign funct = if_instr[5:0];
  assign rs    = RA_W'(if_instr[25:21]);
  assign rt    = RA_W'(if_instr[20:16]);
  assign rd    = RA_W'(if_instr[15:11]);
  assign unused_shamt = ^if_instr[10:6];

  ctrl_t          d_ctrl;
  logic [3:0]     d_alu;
  logic [RA_W-1:0] d_dst;
  logic [XLEN-1:0] d_imm;
  logic [XLEN-1:0] d_brt;

  assign d_imm = {{(XLEN-16){if_instr[15]}}, if_instr[15:0]};
  assign d_brt = if_pc4 + (d_imm << 2);

  always_comb begin
    d_ctrl = '0;
    d_alu  = ALU_ADD;
    d_dst  = '0;
    unique case (op)
      6'h00: begin
        d_dst = rd;
        d_ctrl.regwrite = 1'b1;
        unique case (funct)
          6'h20: d_alu = ALU_ADD;
          6'h22: d_alu = ALU_SUB;
          6'h24: d_alu = ALU_AND;
          6'h25: d_alu = ALU_OR;
          6'h2A: d_alu = ALU_SLT;
          default: begin
            d_ctrl.regwrite = 1'b0;
            d_ctrl.illegal  = 1'b1;
          end
        endcase
      end
      6'h23: begin
        d_dst = rt;
        d_ctrl.regwrite = 1'b1;
        d_ctrl.memread  = 1'b1;
        d_ctrl.memtoreg = 1'b1;
        d_ctrl.alusrc   = 1'b1;
      end
      6'h2B: begin
        d_ctrl.memwrite = 1'b1;
        d_ctrl.alusrc   = 1'b1;
      end
      6'h04: begin
        d_ctrl.branch = 1'b1;
        d_alu = ALU_SUB;
      end
      6'h08: begin
        d_dst = rt;
        d_ctrl.regwrite = 1'b1;
        d_ctrl.alusrc   = 1'b1;
      end
      6'h02: ;
      default: d_ctrl.illegal = 1'b1;
    endcase
  end

  // rt is only a true source for R-type, sw and beq.
  logic rt_src;
  logic ld_use;
  assign rt_src = (op == 6'h00) | (op == 6'h2B) | (op == 6'h04);
  assign ld_use = (ex_rt == rs) | ((ex_rt == rt) & rt_src);
  assign hazard_stall = if_valid & ex_valid & ex_memread
                      & (ex_rt != '0) & ld_use;

  assign jump_target = {if_pc4[XLEN-1:28], if_instr[25:0], 2'b00};
  assign jump_redirect = if_valid & (op == 6'h02) & ~hazard_stall
                       & ~stall_in & ~flush_in;

  logic bubble;
  logic load;
  logic count;
  assign bubble = flush_in | (~stall_in & (hazard_stall | ~if_valid));
  assign load   = ~flush_in & ~stall_in & ~hazard_stall & if_valid;
  assign count  = flush_in | (~stall_in & hazard_stall);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ex_valid     <= 1'b0;
      ex_pc4       <= '0;
      ex_rs_data   <= '0;
      ex_rt_data   <= '0;
      ex_imm       <= '0;
      ex_br_target <= '0;
      ex_rs        <= '0;
      ex_rt        <= '0;
      ex_dst       <= '0;
      ex_alu_ctrl  <= '0;
      ex_regwrite  <= 1'b0;
      ex_memread   <= 1'b0;
      ex_memwrite  <= 1'b0;
      ex_memtoreg  <= 1'b0;
      ex_alusrc    <= 1'b0;
      ex_branch    <= 1'b0;
      ex_illegal   <= 1'b0;
      bubble_cnt   <= '0;
    end else begin
      if (bubble) begin
        ex_valid    <= 1'b0;
        ex_regwrite <= 1'b0;
        ex_memread  <= 1'b0;
        ex_memwrite <= 1'b0;
        ex_memtoreg <= 1'b0;
        ex_alusrc   <= 1'b0;
        ex_branch   <= 1'b0;
        ex_illegal  <= 1'b0;
      end else if (load) begin
        ex_valid     <= 1'b1;
        ex_pc4       <= if_pc4;
        ex_rs_data   <= rs_data;
        ex_rt_data   <= rt_data;
        ex_imm       <= d_imm;
        ex_br_target <= d_brt;
        ex_rs        <= rs;
        ex_rt        <= rt;
        ex_dst       <= d_dst;
        ex_alu_ctrl  <= d_alu;
        ex_regwrite  <= d_ctrl.regwrite;
        ex_memread   <= d_ctrl.memread;
        ex_memwrite  <= d_ctrl.memwrite;
        ex_memtoreg  <= d_ctrl.memtoreg;
        ex_alusrc    <= d_ctrl.alusrc;
        ex_branch    <= d_ctrl.branch;
        ex_illegal   <= d_ctrl.illegal;
      end
      if (count && (bubble_cnt != '1)) begin
        bubble_cnt <= bubble_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_decode_pipe.sv
// tb_decode_pipe: directed checks of decode_pipe decode, interlock,
// jump, stall/flush priority, bubble counter saturation and async reset.
module tb_decode_pipe;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_valid;
  logic [31:0] if_pc4;
  logic [31:0] if_instr;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic        stall_in;
  logic        flush_in;
  logic        hazard_stall;
  logic        jump_redirect;
  logic [31:0] jump_target;
  logic        ex_valid;
  logic [31:0] ex_pc4;
  logic [31:0] ex_rs_data;
  logic [31:0] ex_rt_data;
  logic [31:0] ex_imm;
  logic [31:0] ex_br_target;
  logic [4:0]  ex_rs;
  logic [4:0]  ex_rt;
  logic [4:0]  ex_dst;
  logic [3:0]  ex_alu_ctrl;
  logic        ex_regwrite;
  logic        ex_memread;
  logic        ex_memwrite;
  logic        ex_memtoreg;
  logic        ex_alusrc;
  logic        ex_branch;
  logic        ex_illegal;
  logic [15:0] bubble_cnt;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  decode_pipe dut (
    .clk(clk), .reset(reset),
    .if_valid(if_valid), .if_pc4(if_pc4), .if_instr(if_instr),
    .rs_data(rs_data), .rt_data(rt_data),
    .stall_in(stall_in), .flush_in(flush_in),
    .hazard_stall(hazard_stall), .jump_redirect(jump_redirect),
    .jump_target(jump_target),
    .ex_valid(ex_valid), .ex_pc4(ex_pc4),
    .ex_rs_data(ex_rs_data), .ex_rt_data(ex_rt_data),
    .ex_imm(ex_imm), .ex_br_target(ex_br_target),
    .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_dst(ex_dst),
    .ex_alu_ctrl(ex_alu_ctrl),
    .ex_regwrite(ex_regwrite), .ex_memread(ex_memread),
    .ex_memwrite(ex_memwrite), .ex_memtoreg(ex_memtoreg),
    .ex_alusrc(ex_alusrc), .ex_branch(ex_branch),
    .ex_illegal(ex_illegal), .bubble_cnt(bubble_cnt)
  );

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] pc4,
                       input logic [31:0] ins);
    if_valid = v;
    if_pc4   = pc4;
    if_instr = ins;
    #1;
  endtask

  function automatic logic [6:0] ctl();
    return {ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg,
            ex_alusrc, ex_branch, ex_illegal};
  endfunction

  logic [5:0] fn_tab [5] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};
  logic [3:0] alu_tab [5] = '{4'b0010, 4'b0110, 4'b0000, 4'b0001, 4'b0111};

  initial begin
    reset = 1'b0;
    if_valid = 1'b0;
    if_pc4 = '0;
    if_instr = '0;
    rs_data = '0;
    rt_data = '0;
    stall_in = 1'b0;
    flush_in = 1'b0;
    #2;
    chk("rst_valid", ex_valid, 0);
    chk("rst_cnt", bubble_cnt, 0);
    chk("rst_ctl", ctl(), 0);
    step();
    chk("rst_edge_valid", ex_valid, 0);
    reset = 1'b1;

    // add $3,$1,$2
    rs_data = 32'd11;
    rt_data = 32'd22;
    drive(1, 32'h4, 32'h0022_1820);
    chk("add_hz", hazard_stall, 0);
    step();
    chk("add_valid", ex_valid, 1);
    chk("add_dst", ex_dst, 3);
    chk("add_alu", ex_alu_ctrl, 4'b0010);
    chk("add_ctl", ctl(), 7'b1000000);
    chk("add_rs", ex_rs, 1);
    chk("add_rt", ex_rt, 2);
    chk("add_rsd", ex_rs_data, 11);
    chk("add_rtd", ex_rt_data, 22);
    chk("add_pc4", ex_pc4, 4);

    // lw $5,0($1)
    drive(1, 32'h8, 32'h8C25_0000);
    step();
    chk("lw_ctl", ctl(), 7'b1101100);
    chk("lw_dst", ex_dst, 5);
    chk("lw_rt", ex_rt, 5);

    // add $6,$5,$2 hits load-use on rs
    drive(1, 32'hC, 32'h00A2_3020);
    chk("lu_hz", hazard_stall, 1);
    chk("lu_jr", jump_redirect, 0);
    step();
    chk("lu_bub_valid", ex_valid, 0);
    chk("lu_bub_ctl", ctl(), 0);
    chk("lu_cnt", bubble_cnt, 1);
    chk("lu_hz_clear", hazard_stall, 0);
    step();
    chk("lu_add_valid", ex_valid, 1);
    chk("lu_add_dst", ex_dst, 6);
    chk("lu_add_ctl", ctl(), 7'b1000000);
    chk("lu_cnt_hold", bubble_cnt, 1);

    // lw $5 again, then sw $5,0($7): rt hazard
    drive(1, 32'h10, 32'h8C25_0000);
    step();
    drive(1, 32'h14, 32'hACE5_0000);
    chk("sw_rt_hz", hazard_stall, 1);
    // addi $5,$1,7: rt is a destination, no hazard
    drive(1, 32'h14, 32'h2025_0007);
    chk("addi_no_hz", hazard_stall, 0);
    step();
    chk("addi_ctl", ctl(), 7'b1000100);
    chk("addi_dst", ex_dst, 5);
    chk("addi_imm", ex_imm, 7);
    chk("addi_cnt", bubble_cnt, 1);

    // beq $1,$2,-1
    drive(1, 32'h100, 32'h1022_FFFF);
    step();
    chk("beq_brt", ex_br_target, 32'h0FC);
    chk("beq_imm", ex_imm, 32'hFFFF_FFFF);
    chk("beq_ctl", ctl(), 7'b0000010);
    chk("beq_alu", ex_alu_ctrl, 4'b0110);

    // j 0x40
    drive(1, 32'h1000_0004, 32'h0800_0040);
    chk("j_jr", jump_redirect, 1);
    chk("j_tgt", jump_target, 32'h1000_0100);
    stall_in = 1'b1;
    #1;
    chk("j_stall_jr", jump_redirect, 0);
    step();
    chk("j_stall_hold_br", ex_branch, 1);
    chk("j_stall_hold_brt", ex_br_target, 32'h0FC);
    chk("j_stall_hold_v", ex_valid, 1);
    stall_in = 1'b0;
    #1;
    chk("j_jr2", jump_redirect, 1);
    step();
    chk("j_valid", ex_valid, 1);
    chk("j_ctl", ctl(), 0);
    chk("j_pc4", ex_pc4, 32'h1000_0004);

    // R-type bad funct
    drive(1, 32'h20, 32'h0022_183F);
    step();
    chk("badfn_ctl", ctl(), 7'b0000001);
    chk("badfn_alu", ex_alu_ctrl, 4'b0010);

    for (int i = 0; i < 5; i++) begin
      drive(1, 32'h24, {26'h0008_860, fn_tab[i]});
      step();
      chk($sformatf("rfn_alu_%0d", i), ex_alu_ctrl, alu_tab[i]);
      chk($sformatf("rfn_ctl_%0d", i), ctl(), 7'b1000000);
    end

    // undefined opcode 0x3F
    drive(1, 32'h28, 32'hFC00_0000);
    step();
    chk("op3f_ctl", ctl(), 7'b0000001);
    chk("op3f_valid", ex_valid, 1);

    // invalid slot: bubble, not counted
    drive(0, 32'h2C, 32'h0022_1820);
    step();
    chk("inv_valid", ex_valid, 0);
    chk("inv_ctl", ctl(), 0);
    chk("inv_cnt", bubble_cnt, 1);

    // flush beats stall
    drive(1, 32'h30, 32'h0022_1820);
    step();
    chk("pre_fl_valid", ex_valid, 1);
    flush_in = 1'b1;
    stall_in = 1'b1;
    #1;
    step();
    chk("fs_valid", ex_valid, 0);
    chk("fs_ctl", ctl(), 0);
    chk("fs_cnt", bubble_cnt, 2);
    stall_in = 1'b0;

    // drive counter to saturation
    if_valid = 1'b0;
    for (int i = 0; i < 65533; i++) step();
    chk("sat_cnt_max", bubble_cnt, 16'hFFFF);
    step();
    chk("sat_cnt_hold", bubble_cnt, 16'hFFFF);
    flush_in = 1'b0;

    // async reset mid-cycle
    drive(1, 32'h40, 32'h8C25_0000);
    step();
    chk("pre_rst_ctl", ctl(), 7'b1101100);
    #2;
    reset = 1'b0;
    #1;
    chk("arst_valid", ex_valid, 0);
    chk("arst_ctl", ctl(), 0);
    chk("arst_cnt", bubble_cnt, 0);
    chk("arst_dst", ex_dst, 0);
    chk("arst_pc4", ex_pc4, 0);

    // reset during stall discards the held instruction
    stall_in = 1'b1;
    step();
    #2;
    reset = 1'b1;
    step();
    chk("rst_stall_valid", ex_valid, 0);
    stall_in = 1'b0;
    drive(1, 32'h44, 32'h2025_0007);
    step();
    chk("post_rst_valid", ex_valid, 1);
    chk("post_rst_ctl", ctl(), 7'b1000100);
    chk("post_rst_cnt", bubble_cnt, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
